// File: rtl/operand_fetch.sv
// Operand fetch: reads an opcode plus 0-2 extension words from program
// memory and holds the decoded immediate bundle until it is accepted.
module operand_fetch #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       opcode,
  output logic [ADDR_W-1:0] op_pc,
  output logic [15:0]       imm16,
  output logic [31:0]       imm32,
  output logic              imm_sel,
  output logic              fetch_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, F_OP, F_EXT1, F_EXT2, HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [15:0]       opcode_q, opcode_d;
  logic [ADDR_W-1:0] op_pc_q, op_pc_d;
  logic [15:0]       imm16_q, imm16_d;
  logic [31:0]       imm32_q, imm32_d;
  logic              imm_sel_q, imm_sel_d;
  logic              mem_req_q, mem_req_d;
  logic              out_valid_q, out_valid_d;
  logic              fetch_err_q, fetch_err_d;
  logic              xfer;

  assign xfer = mem_req_q && mem_ack;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    opcode_d    = opcode_q;
    op_pc_d     = op_pc_q;
    imm16_d     = imm16_q;
    imm32_d     = imm32_q;
    imm_sel_d   = imm_sel_q;
    fetch_err_d = 1'b0;

    if (xfer) begin
      cnt_d = '0;
    end else if (mem_req_q) begin
      cnt_d = cnt_q + CW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (fetch_en) begin
          state_d = F_OP;
          cnt_d   = '0;
        end
      end
      F_OP: begin
        if (xfer) begin
          opcode_d = mem_rdata;
          op_pc_d  = pc_q;
          pc_d     = pc_q + ADDR_W'(1);
          if (mem_rdata[15:14] == 2'b00) begin
            imm16_d   = '0;
            imm32_d   = '0;
            imm_sel_d = 1'b1;
            state_d   = HOLD;
          end else begin
            state_d = F_EXT1;
          end
        end
      end
      F_EXT1: begin
        if (xfer) begin
          pc_d = pc_q + ADDR_W'(1);
          if (opcode_q[15]) begin
            imm32_d[31:16] = mem_rdata;
            state_d        = F_EXT2;
          end else begin
            imm16_d   = mem_rdata;
            imm32_d   = '0;
            imm_sel_d = 1'b1;
            state_d   = HOLD;
          end
        end
      end
      F_EXT2: begin
        if (xfer) begin
          pc_d          = pc_q + ADDR_W'(1);
          imm32_d[15:0] = mem_rdata;
          imm16_d       = '0;
          imm_sel_d     = 1'b0;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = fetch_en ? F_OP : IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort rewinds to the opcode address so the whole instruction refetches.
    if (mem_req_q && !mem_ack && cnt_q == CW'(TIMEOUT - 1)) begin
      state_d     = IDLE;
      fetch_err_d = 1'b1;
      cnt_d       = '0;
      pc_d        = (state_q == F_OP) ? pc_q : op_pc_q;
    end

    if (pc_load) begin
      state_d     = IDLE;
      pc_d        = pc_load_val;
      cnt_d       = '0;
      fetch_err_d = 1'b0;
      opcode_d    = opcode_q;
      op_pc_d     = op_pc_q;
      imm16_d     = imm16_q;
      imm32_d     = imm32_q;
      imm_sel_d   = imm_sel_q;
    end

    mem_req_d   = (state_d == F_OP) || (state_d == F_EXT1) ||
                  (state_d == F_EXT2);
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      cnt_q       <= '0;
      opcode_q    <= '0;
      op_pc_q     <= '0;
      imm16_q     <= '0;
      imm32_q     <= '0;
      imm_sel_q   <= 1'b1;
      mem_req_q   <= 1'b0;
      out_valid_q <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      opcode_q    <= opcode_d;
      op_pc_q     <= op_pc_d;
      imm16_q     <= imm16_d;
      imm32_q     <= imm32_d;
      imm_sel_q   <= imm_sel_d;
      mem_req_q   <= mem_req_d;
      out_valid_q <= out_valid_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = pc_q;
  assign out_valid = out_valid_q;
  assign opcode    = opcode_q;
  assign op_pc     = op_pc_q;
  assign imm16     = imm16_q;
  assign imm32     = imm32_q;
  assign imm_sel   = imm_sel_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: vector table, corner-case sequences and a
// randomized run checked against an instruction-stream model.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_val = '0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] opcode;
  logic [15:0] op_pc;
  logic [15:0] imm16;
  logic [31:0] imm32;
  logic        imm_sel;
  logic        fetch_err;

  operand_fetch dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .pc_load(pc_load), .pc_load_val(pc_load_val),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .op_pc(op_pc), .imm16(imm16),
    .imm32(imm32), .imm_sel(imm_sel), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  assign mem_rdata = mem[mem_addr];

  // memory responder: 0 tied, 1 fixed wait, 2 never, 3 random, 4 budget
  int   ack_mode = 0;
  int   lat = 0;
  int   wcnt = 0;
  int   xfers = 0;
  int   base = 0;
  int   budget = 0;
  logic rnd_ack = 1'b1;

  always @(posedge clk) begin
    wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
    if (mem_req && mem_ack) xfers <= xfers + 1;
  end

  always_comb begin
    mem_ack = 1'b0;
    case (ack_mode)
      0: mem_ack = 1'b1;
      1: mem_ack = mem_req && (wcnt >= lat);
      3: mem_ack = rnd_ack;
      4: mem_ack = mem_req && ((xfers - base) < budget);
      default: mem_ack = 1'b0;
    endcase
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!out_valid && cyc < 40);
  endtask

  task automatic wait_err(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!fetch_err && cyc < 40);
  endtask

  task automatic check_reset(input string t);
    check({t, "_req"}, 32'(mem_req), 0);
    check({t, "_addr"}, 32'(mem_addr), 0);
    check({t, "_valid"}, 32'(out_valid), 0);
    check({t, "_err"}, 32'(fetch_err), 0);
    check({t, "_opcode"}, 32'(opcode), 0);
    check({t, "_op_pc"}, 32'(op_pc), 0);
    check({t, "_imm16"}, 32'(imm16), 0);
    check({t, "_imm32"}, imm32, 0);
    check({t, "_sel"}, 32'(imm_sel), 1);
  endtask

  task automatic redirect(input logic [15:0] a);
    pc_load = 1'b1;
    pc_load_val = a;
    step();
    pc_load = 1'b0;
  endtask

  // instruction-stream model for the randomized run
  logic        mon_en = 1'b0;
  logic [15:0] mpc = '0;
  int          n_acc = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (pc_load) begin
        mpc = pc_load_val;
      end else if (out_valid && out_ready) begin
        logic [15:0] op;
        logic [15:0] e16;
        logic [31:0] e32;
        logic        esel;
        int          len;
        op = mem[mpc];
        e16 = '0;
        e32 = '0;
        esel = 1'b1;
        len = 1;
        if (op[15]) begin
          e32 = {mem[mpc + 16'd1], mem[mpc + 16'd2]};
          esel = 1'b0;
          len = 3;
        end else if (op[14]) begin
          e16 = mem[mpc + 16'd1];
          len = 2;
        end
        check("rnd_opcode", 32'(opcode), 32'(op));
        check("rnd_op_pc", 32'(op_pc), 32'(mpc));
        check("rnd_imm16", 32'(imm16), 32'(e16));
        check("rnd_imm32", imm32, e32);
        check("rnd_sel", 32'(imm_sel), 32'(esel));
        mpc = mpc + 16'(len);
        n_acc++;
      end
    end
  end

  typedef struct {
    logic [15:0] addr;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] w2;
    int          lat;
    logic [15:0] e_imm16;
    logic [31:0] e_imm32;
    logic        e_sel;
    int          e_cyc;
    logic [15:0] e_next;
  } vec_t;

  initial begin
    vec_t tv [7];
    int   cyc;

    tv[0] = '{16'h0000, 16'h0123, 16'h0000, 16'h0000, -1,
              16'h0000, 32'h0, 1'b1, 1, 16'h0001};
    tv[1] = '{16'h0004, 16'h4005, 16'hBEEF, 16'h0000, -1,
              16'hBEEF, 32'h0, 1'b1, 2, 16'h0006};
    tv[2] = '{16'h0008, 16'h8001, 16'h1234, 16'h5678, 2,
              16'h0000, 32'h12345678, 1'b0, 9, 16'h000B};
    tv[3] = '{16'hFFFF, 16'hC0DE, 16'hAAAA, 16'h5555, -1,
              16'h0000, 32'hAAAA5555, 1'b0, 3, 16'h0002};
    tv[4] = '{16'h0020, 16'h7FFF, 16'h0001, 16'h0000, -1,
              16'h0001, 32'h0, 1'b1, 2, 16'h0022};
    tv[5] = '{16'h0030, 16'h3ABC, 16'h0000, 16'h0000, 1,
              16'h0000, 32'h0, 1'b1, 2, 16'h0031};
    tv[6] = '{16'hFFFE, 16'h4321, 16'h5A5A, 16'h0000, -1,
              16'h5A5A, 32'h0, 1'b1, 2, 16'h0000};

    for (int a = 0; a < 65536; a++) mem[a] = '0;

    step();
    step();
    check_reset("reset");
    rst = 1'b0;

    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      mem[tv[i].addr] = tv[i].w0;
      mem[tv[i].addr + 16'd1] = tv[i].w1;
      mem[tv[i].addr + 16'd2] = tv[i].w2;
      ack_mode = (tv[i].lat < 0) ? 0 : 1;
      lat = (tv[i].lat < 0) ? 0 : tv[i].lat;
      redirect(tv[i].addr);
      fetch_en = 1'b1;
      step();
      check($sformatf("v%0d_req", i), 32'(mem_req), 1);
      check($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(tv[i].addr));
      fetch_en = 1'b0;
      wait_valid(cyc);
      check($sformatf("v%0d_latency", i), cyc, tv[i].e_cyc);
      check($sformatf("v%0d_opcode", i), 32'(opcode), 32'(tv[i].w0));
      check($sformatf("v%0d_op_pc", i), 32'(op_pc), 32'(tv[i].addr));
      check($sformatf("v%0d_imm16", i), 32'(imm16), 32'(tv[i].e_imm16));
      check($sformatf("v%0d_imm32", i), imm32, tv[i].e_imm32);
      check($sformatf("v%0d_sel", i), 32'(imm_sel), 32'(tv[i].e_sel));
      check($sformatf("v%0d_hold_req", i), 32'(mem_req), 0);
      check($sformatf("v%0d_next", i), 32'(mem_addr), 32'(tv[i].e_next));
      step();
      check($sformatf("v%0d_drop", i), 32'(out_valid), 0);
    end

    // backpressure, then back-to-back fetch
    ack_mode = 0;
    mem[16'h0040] = 16'h4011;
    mem[16'h0041] = 16'h2222;
    mem[16'h0042] = 16'h0042;
    out_ready = 1'b0;
    redirect(16'h0040);
    fetch_en = 1'b1;
    wait_valid(cyc);
    check("bp_valid", 32'(out_valid), 1);
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_valid_held", 32'(out_valid), 1);
      check("bp_opcode", 32'(opcode), 32'h4011);
      check("bp_imm16", 32'(imm16), 32'h2222);
      check("bp_req", 32'(mem_req), 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    fetch_en = 1'b0;
    check("b2b_valid", 32'(out_valid), 0);
    check("b2b_req", 32'(mem_req), 1);
    check("b2b_addr", 32'(mem_addr), 32'h0042);
    wait_valid(cyc);
    check("b2b_opcode", 32'(opcode), 32'h0042);
    check("b2b_op_pc", 32'(op_pc), 32'h0042);
    check("b2b_imm16", 32'(imm16), 0);
    out_ready = 1'b1;
    step();

    // ack never arrives on the opcode word
    ack_mode = 2;
    mem[16'h0050] = 16'h0050;
    redirect(16'h0050);
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    wait_err(cyc);
    check("to_cycles", cyc, 15);
    check("to_req", 32'(mem_req), 0);
    check("to_valid", 32'(out_valid), 0);
    step();
    check("to_pulse", 32'(fetch_err), 0);
    ack_mode = 0;
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    check("to_retry_addr", 32'(mem_addr), 32'h0050);
    wait_valid(cyc);
    check("to_retry_opcode", 32'(opcode), 32'h0050);
    step();

    // ack stops after two words of a long instruction
    mem[16'h0060] = 16'h8060;
    mem[16'h0061] = 16'hAAAA;
    mem[16'h0062] = 16'hBBBB;
    redirect(16'h0060);
    base = xfers;
    budget = 2;
    ack_mode = 4;
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    wait_err(cyc);
    check("to2_cycles", cyc, 17);
    check("to2_req", 32'(mem_req), 0);
    check("to2_pc", 32'(mem_addr), 32'h0060);
    ack_mode = 0;

    // redirect while the first extension word is acked
    mem[16'h0070] = 16'h4000;
    mem[16'h0071] = 16'h9999;
    mem[16'h0100] = 16'h0100;
    redirect(16'h0070);
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    step();
    check("pl_ext1_addr", 32'(mem_addr), 32'h0071);
    redirect(16'h0100);
    check("pl_req", 32'(mem_req), 0);
    check("pl_valid", 32'(out_valid), 0);
    check("pl_err", 32'(fetch_err), 0);
    check("pl_addr", 32'(mem_addr), 32'h0100);
    step();
    step();
    step();
    check("pl_no_bundle", 32'(out_valid), 0);
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    check("pl_fetch_req", 32'(mem_req), 1);
    check("pl_fetch_addr", 32'(mem_addr), 32'h0100);
    wait_valid(cyc);
    check("pl_opcode", 32'(opcode), 32'h0100);
    step();

    // reset while waiting in the second extension word
    ack_mode = 1;
    lat = 3;
    mem[16'h0080] = 16'h8080;
    mem[16'h0081] = 16'h1111;
    mem[16'h0082] = 16'h2222;
    redirect(16'h0080);
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    for (int k = 0; k < 9; k++) step();
    check("rst_ext2_addr", 32'(mem_addr), 32'h0082);
    rst = 1'b1;
    step();
    check_reset("midrst");
    rst = 1'b0;
    ack_mode = 0;
    step();

    // randomized stream
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    ack_mode = 3;
    pc_load = 1'b1;
    pc_load_val = 16'hFFF0;
    mon_en = 1'b1;
    step();
    pc_load = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      fetch_en = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rnd_ack = ($urandom_range(0, 3) != 0);
      pc_load = ($urandom_range(0, 99) == 0);
      pc_load_val = ($urandom_range(0, 1) == 0) ?
                    16'($urandom_range(16'hFFFC, 16'hFFFF)) :
                    16'($urandom);
      step();
    end
    mon_en = 1'b0;
    pc_load = 1'b0;
    check("rnd_accepts", 32'(n_acc > 100), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
